myhardware_pio_in_irq: RTL and testbench

//  Avalon-MM slave input port for push-buttons/switches, complementing the LED output PIO.

---
 rtl/myhardware_pio_in_irq.sv | 117 +++++++++++
 tb/tb_myhardware_pio_in_irq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/myhardware_pio_in_irq.sv
// Avalon-MM input PIO: synchronises and debounces in_port, captures edges into
// sticky flags and raises a maskable level interrupt.
module myhardware_pio_in_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RAW     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] rise, fall, edge_evt, clr;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic             wr_en;
    logic             irq_d;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    // Two-flop synchroniser on the raw asynchronous inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rise = stable_d & ~stable_q;
        fall = stable_q & ~stable_d;
        case (EDGE_TYPE)
            0:       edge_evt = rise;
            1:       edge_evt = fall;
            default: edge_evt = rise | fall;
        endcase
    end

    // Register writes; an edge event outranks a same-cycle W1C clear
    always_comb begin
        wr_en     = chipselect & ~write_n;
        clr       = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        mask_d    = (wr_en && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;
        edgecap_d = (edgecap_q & ~clr) | edge_evt;
        irq_d     = |(edgecap_d & mask_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q  <= '0;
            mask_q    <= '0;
            edgecap_q <= '0;
            irq       <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
            irq       <= irq_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-wait-state read mux, zero-extended above WIDTH
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = 32'(stable_q);
            ADDR_RAW:     readdata = 32'(sync2_q);
            ADDR_IRQMASK: readdata = 32'(mask_q);
            ADDR_EDGECAP: readdata = 32'(edgecap_q);
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_myhardware_pio_in_irq.sv
// Bench for myhardware_pio_in_irq: directed scenarios plus random input/bus
// traffic, checked against a sliding-window reference model.
module tb_myhardware_pio_in_irq;

    localparam int unsigned W = 4;
    localparam int unsigned D = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    myhardware_pio_in_irq #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .EDGE_TYPE(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: hist[k] is the in_port value sampled k+1 edges ago.
    // A bit's accepted level flips once the D samples seen by the debouncer
    // (those 2..D+1 edges old) all disagree with it.
    logic [W-1:0] hist [D+2];
    logic [W-1:0] stable_m, mask_m, ecap_m;
    logic [W-1:0] m_next, m_clr;
    logic         m_flip;
    logic         m_wr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < D + 2; k++) hist[k] = '0;
            stable_m = '0;
            mask_m   = '0;
            ecap_m   = '0;
        end else begin
            m_next = stable_m;
            for (int i = 0; i < W; i++) begin
                m_flip = 1'b1;
                for (int k = 1; k <= D; k++) begin
                    if (hist[k][i] == stable_m[i]) m_flip = 1'b0;
                end
                if (m_flip) m_next[i] = ~stable_m[i];
            end
            m_wr  = chipselect && !write_n;
            m_clr = (m_wr && address == 2'd3) ? writedata[W-1:0] : '0;
            ecap_m = (ecap_m & ~m_clr) | (stable_m & ~m_next);
            if (m_wr && address == 2'd2) mask_m = writedata[W-1:0];
            stable_m = m_next;
            for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = in_port;
        end
    end

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    model_reg = 32'(stable_m);
            2'd1:    model_reg = 32'(hist[1]);
            2'd2:    model_reg = 32'(mask_m);
            default: model_reg = 32'(ecap_m);
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then compare against the model after the edge
    task automatic step(input logic [W-1:0] inp, input logic wr, input logic [1:0] a,
                        input logic [31:0] wd);
        in_port   = inp;
        address   = a;
        writedata = wd;
        if (wr) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
            chipselect = 1'b0;
            write_n    = 1'b0;
        end else begin
            chipselect = 1'b1;
            write_n    = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("model_rd", readdata, model_reg(a));
        check_eq("model_irq", 32'(irq), 32'(|(ecap_m & mask_m)));
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            check_eq(tag, readdata, 32'h0);
        end
        check_eq({tag, "_irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        logic [W-1:0] pat;
        int           len;
        reset_n    = 1'b0;
        in_port    = 4'hF;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Input held high through reset: accepted on the 6th edge, not captured
        for (int c = 1; c <= 6; c++) begin
            step(4'hF, 1'b0, 2'd0, 32'h0);
            if (c == 5) check_eq("t1_data_pre", readdata, 32'h0);
            if (c == 6) check_eq("t1_data", readdata, 32'hF);
        end
        step(4'hF, 1'b0, 2'd3, 32'h0);
        check_eq("t1_ecap", readdata, 32'h0);

        // Short glitch is rejected
        step(4'hF, 1'b1, 2'd2, 32'h1);
        for (int c = 0; c < 3; c++) step(4'hE, 1'b0, 2'd0, 32'h0);
        for (int c = 0; c < 8; c++) step(4'hF, 1'b0, 2'd0, 32'h0);
        check_eq("t2_data", readdata, 32'hF);
        step(4'hF, 1'b0, 2'd3, 32'h0);
        check_eq("t2_ecap", readdata, 32'h0);
        check_eq("t2_irq", 32'(irq), 32'h0);

        // Held falling edge: DATA, EDGECAP and irq change together
        for (int c = 1; c <= 6; c++) begin
            step(4'hE, 1'b0, 2'd0, 32'h0);
            if (c == 5) check_eq("t3_data_pre", readdata, 32'hF);
            if (c == 6) begin
                check_eq("t3_data", readdata, 32'hE);
                check_eq("t3_irq", 32'(irq), 32'h1);
            end
        end
        step(4'hE, 1'b0, 2'd3, 32'h0);
        check_eq("t3_ecap", readdata, 32'h1);

        // W1C clear, then a clear colliding with a new falling edge
        step(4'hE, 1'b1, 2'd3, 32'h1);
        check_eq("t4_clr", readdata, 32'h0);
        check_eq("t4_clr_irq", 32'(irq), 32'h0);
        for (int c = 0; c < 6; c++) step(4'hF, 1'b0, 2'd0, 32'h0);
        for (int c = 1; c <= 6; c++) step(4'hE, c == 6, 2'd3, 32'h1);
        check_eq("t4_setwins", readdata, 32'h1);
        check_eq("t4_setwins_irq", 32'(irq), 32'h1);

        // Masked capture, late unmask, write-0 leaves the flag
        step(4'hE, 1'b1, 2'd3, 32'hF);
        step(4'hE, 1'b1, 2'd2, 32'h0);
        for (int c = 0; c < 6; c++) step(4'hA, 1'b0, 2'd3, 32'h0);
        check_eq("t5_ecap", readdata, 32'h4);
        check_eq("t5_irq_masked", 32'(irq), 32'h0);
        step(4'hA, 1'b1, 2'd2, 32'h4);
        check_eq("t5_irq_unmask", 32'(irq), 32'h1);
        step(4'hA, 1'b1, 2'd3, 32'h0);
        check_eq("t5_ecap_keep", readdata, 32'h4);
        check_eq("t5_irq_keep", 32'(irq), 32'h1);

        // Asynchronous reset mid-debounce
        for (int c = 0; c < 3; c++) step(4'hF, 1'b0, 2'd0, 32'h0);
        write_n = 1'b1;
        reset_n = 1'b0;
        check_all_zero("t6_reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 7; c++) step(4'hF, 1'b0, 2'd0, 32'h0);

        // Random traffic with a mid-run reset
        pat = 4'hF;
        for (int blk = 0; blk < 120; blk++) begin
            if (blk == 60) begin
                write_n = 1'b1;
                reset_n = 1'b0;
                check_all_zero("rand_reset");
                @(negedge clk);
                reset_n = 1'b1;
            end
            pat ^= W'($urandom);
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                step(pat, $urandom_range(0, 3) == 0, 2'($urandom), $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
